// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC core: opcodes, ALU function codes, FSM states and stat bits.
// Build option SISC_MUL_EN adds MUL (mm 8) to the legal ALU functions.
package sisc_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ALU_R = 4'd1;
  localparam logic [3:0] OP_ALU_I = 4'd2;
  localparam logic [3:0] OP_BRA   = 4'd4;
  localparam logic [3:0] OP_JMP   = 4'd5;
  localparam logic [3:0] OP_LD    = 4'd8;
  localparam logic [3:0] OP_ST    = 4'd9;
  localparam logic [3:0] OP_HALT  = 4'd15;

  localparam logic [3:0] MM_ADD = 4'd0;
  localparam logic [3:0] MM_SUB = 4'd1;
  localparam logic [3:0] MM_AND = 4'd2;
  localparam logic [3:0] MM_OR  = 4'd3;
  localparam logic [3:0] MM_XOR = 4'd4;
  localparam logic [3:0] MM_NOT = 4'd5;
  localparam logic [3:0] MM_SHL = 4'd6;
  localparam logic [3:0] MM_SHR = 4'd7;
  localparam logic [3:0] MM_MUL = 4'd8;

  localparam int STAT_Z = 0;
  localparam int STAT_N = 1;
  localparam int STAT_V = 2;
  localparam int STAT_C = 3;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Any mm code outside this set turns an ALU opcode into a NOP.
  function automatic logic alu_mm_ok(input logic [3:0] mm);
`ifdef SISC_MUL_EN
    return (mm <= MM_MUL);
`else
    return (mm <= MM_SHR);
`endif
  endfunction

endpackage

// File: rtl/sisc_alu.sv
// SISC combinational ALU: operands and mm code in, result and {C,V,N,Z} flags out.
// The multiplier exists only when SISC_MUL_EN is defined.
module sisc_alu
  import sisc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        mm,
  output logic [DATA_W-1:0] res,
  output logic [3:0]        flags
);

  logic signed [DATA_W-1:0] sa, sb, sum_s, dif_s;
  logic [DATA_W:0]          sum_x, dif_x;
  logic                     c, v;

  assign sa    = a;
  assign sb    = b;
  assign sum_x = {1'b0, a} + {1'b0, b};
  assign dif_x = {1'b0, a} - {1'b0, b};
  assign sum_s = sum_x[DATA_W-1:0];
  assign dif_s = dif_x[DATA_W-1:0];

`ifdef SISC_MUL_EN
  logic [2*DATA_W-1:0] prod;
  assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif

  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (mm)
      MM_ADD: begin
        res = sum_x[DATA_W-1:0];
        c   = sum_x[DATA_W];
        v   = ((sa < 0) == (sb < 0)) && ((sum_s < 0) != (sa < 0));
      end
      MM_SUB: begin
        res = dif_x[DATA_W-1:0];
        c   = ~dif_x[DATA_W];
        v   = ((sa < 0) != (sb < 0)) && ((dif_s < 0) != (sa < 0));
      end
      MM_AND: res = a & b;
      MM_OR:  res = a | b;
      MM_XOR: res = a ^ b;
      MM_NOT: res = ~a;
      MM_SHL: res = {a[DATA_W-2:0], 1'b0};
      MM_SHR: res = {1'b0, a[DATA_W-1:1]};
`ifdef SISC_MUL_EN
      MM_MUL: begin
        res = prod[DATA_W-1:0];
        c   = |prod[2*DATA_W-1:DATA_W];
      end
`endif
      default: res = '0;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[STAT_C] = c;
    flags[STAT_V] = v;
    flags[STAT_N] = res[DATA_W-1];
    flags[STAT_Z] = (res == '0);
  end

endmodule

// File: rtl/sisc_core.sv
// SISC multicycle core: FETCH/DECODE/EXEC/MEM/WB/HALT FSM, register file and stat flags.
// Defining SISC_MUL_EN enables the MUL ALU function (see sisc_pkg / sisc_alu).
module sisc_core
  import sisc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int PC_W   = 16
) (
  input  logic              clk,
  input  logic              rst_f,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [PC_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [PC_W-1:0]   pc,
  output logic [3:0]        stat,
  output logic              halted
);

  state_t                   state, state_n;
  logic                     fetch_en;
  logic [31:0]              ir_p0;
  logic [3:0]               op, mm, rd, rs, rt;
  logic [15:0]              imm;
  logic signed [15:0]       imm_s;
  logic signed [DATA_W-1:0] rf [NREG];
  logic signed [DATA_W-1:0] rs_val, rt_val, rd_val;
  logic signed [DATA_W-1:0] opa_p1, opb_p1, sd_p1;
  logic signed [DATA_W-1:0] res_p2;
  logic [3:0]               flg_p2;
  logic [PC_W-1:0]          addr_p2;
  logic [DATA_W-1:0]        alu_res;
  logic [3:0]               alu_flg;
  logic                     is_alu, is_br, br_take;

  assign op    = ir_p0[31:28];
  assign mm    = ir_p0[27:24];
  assign rd    = ir_p0[23:20];
  assign rs    = ir_p0[19:16];
  assign rt    = ir_p0[15:12];
  assign imm   = ir_p0[15:0];
  assign imm_s = imm;

  assign is_alu  = (op == OP_ALU_R) || (op == OP_ALU_I);
  assign is_br   = (op == OP_BRA) || (op == OP_JMP);
  assign br_take = (mm == 4'd0) || ((mm & stat) != 4'd0);

  assign imem_addr  = pc;
  assign dmem_addr  = addr_p2;
  assign dmem_wdata = sd_p1;

  // Indices at or above NREG read as zero.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    rd_val = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rs == 4'(i)) rs_val = rf[i];
      if (rt == 4'(i)) rt_val = rf[i];
      if (rd == 4'(i)) rd_val = rf[i];
    end
  end

  sisc_alu #(.DATA_W(DATA_W)) u_alu (
    .a     (opa_p1),
    .b     (opb_p1),
    .mm    (mm),
    .res   (alu_res),
    .flags (alu_flg)
  );

  // fetch_en keeps imem_req low until the first edge after reset release.
  always_comb begin
    state_n  = state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    halted   = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req = fetch_en;
        if (fetch_en && imem_ack) state_n = ST_DECODE;
      end
      ST_DECODE: begin
        case (op)
          OP_ALU_R, OP_ALU_I:            state_n = alu_mm_ok(mm) ? ST_EXEC : ST_FETCH;
          OP_BRA, OP_JMP, OP_LD, OP_ST:  state_n = ST_EXEC;
          OP_HALT:                       state_n = ST_HALT;
          OP_NOP:                        state_n = ST_FETCH;
          default:                       state_n = ST_FETCH;
        endcase
      end
      ST_EXEC: begin
        if (is_alu)                           state_n = ST_WB;
        else if (op == OP_LD || op == OP_ST)  state_n = ST_MEM;
        else                                  state_n = ST_FETCH;
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op == OP_ST);
        if (dmem_ack) state_n = (op == OP_ST) ? ST_FETCH : ST_WB;
      end
      ST_WB:   state_n = ST_FETCH;
      ST_HALT: halted  = 1'b1;
      default: state_n = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state    <= ST_FETCH;
      fetch_en <= 1'b0;
      pc       <= '0;
      stat     <= '0;
    end else begin
      state    <= state_n;
      fetch_en <= 1'b1;
      if (state == ST_DECODE)
        pc <= pc + PC_W'(1);
      else if (state == ST_EXEC && is_br && br_take)
        pc <= (op == OP_BRA) ? pc + imm[PC_W-1:0] : imm[PC_W-1:0];
      if (state == ST_WB && is_alu)
        stat <= flg_p2;
    end
  end

  // p0: instruction word; p1: decoded operands; p2: result / address.
  always_ff @(posedge clk) begin
    if (state == ST_FETCH && fetch_en && imem_ack)
      ir_p0 <= imem_rdata;
    if (state == ST_DECODE) begin
      opa_p1 <= rs_val;
      opb_p1 <= (op == OP_ALU_I) ? DATA_W'(imm_s) : rt_val;
      sd_p1  <= rd_val;
    end
    if (state == ST_EXEC) begin
      res_p2  <= alu_res;
      flg_p2  <= alu_flg;
      addr_p2 <= opa_p1[PC_W-1:0] + imm[PC_W-1:0];
    end
    if (state == ST_MEM && dmem_ack)
      res_p2 <= dmem_rdata;
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (state == ST_WB) begin
      for (int i = 0; i < NREG; i++)
        if (rd == 4'(i)) rf[i] <= res_p2;
    end
  end

endmodule

// File: tb/tb_sisc_core.sv
// Directed bench for sisc_core: runs a small program against zero-wait and delayed memories.
module tb_sisc_core;

  localparam int DW = 32;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_f = 1'b1;
  logic          imem_req, imem_ack;
  logic [PW-1:0] imem_addr, dmem_addr, pc;
  logic [31:0]   imem_rdata;
  logic          dmem_req, dmem_we, dmem_ack;
  logic [DW-1:0] dmem_wdata, dmem_rdata;
  logic [3:0]    stat;
  logic          halted;

  logic [31:0]   imem [256];
  logic [DW-1:0] dmem [256];
  int            dly = 0;
  int            cnt = 0;
  logic          ack_force = 1'b0;

  logic          mon_en = 1'b0;
  logic          mon_we = 1'b0;
  logic [PW-1:0] mon_addr = '0;
  logic [DW-1:0] mon_wdata = '0;

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  sisc_core #(.DATA_W(DW), .NREG(16), .PC_W(PW)) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .pc         (pc),
    .stat       (stat),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  assign imem_ack   = imem_req;
  assign imem_rdata = imem[imem_addr[7:0]];
  assign dmem_rdata = dmem[dmem_addr[7:0]];
  assign dmem_ack   = ack_force | (dmem_req && cnt >= dly);

  always @(posedge clk) begin
    if (dmem_req && dmem_we && dmem_ack) dmem[dmem_addr[7:0]] <= dmem_wdata;
    cnt <= (dmem_req && !dmem_ack) ? cnt + 1 : 0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Data request must stay stable for every cycle it is outstanding.
  always @(negedge clk) begin
    if (mon_en && dmem_req) begin
      chk("mem_we", dmem_we, mon_we);
      chk("mem_addr", dmem_addr, mon_addr);
      if (mon_we) chk("mem_wdata", dmem_wdata, mon_wdata);
    end
  end

  // Called in a fetch cycle; returns cycles until the next fetch (or halt).
  task automatic exec1(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(imem_req && imem_ack) && !halted && cyc < 40);
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    imem[0]  = 32'h2010_0005;  // ADDI R1,R0,5
    imem[1]  = 32'h2020_FFF9;  // ADDI R2,R0,-7
    imem[2]  = 32'h1131_1000;  // SUB  R3,R1,R1
    imem[3]  = 32'h5000_0005;  // JMP  5
    imem[4]  = 32'h5000_0006;  // JMP  6
    imem[5]  = 32'h4100_FFFE;  // BRA  Z,-2
    imem[6]  = 32'h2050_FFFF;  // ADDI R5,R0,-1
    imem[7]  = 32'h1755_0000;  // SHR1 R5,R5
    imem[8]  = 32'h2065_0001;  // ADDI R6,R5,1
    imem[9]  = 32'h4100_FFFE;  // BRA  Z,-2
    imem[10] = 32'h9010_0010;  // ST   R1,[R0+0x10]
    imem[11] = 32'h8040_0010;  // LD   R4,[R0+0x10]
    imem[12] = 32'h9040_0011;  // ST   R4,[R0+0x11]
    imem[13] = 32'h9020_0012;  // ST   R2,[R0+0x12]
    imem[14] = 32'h9030_0013;  // ST   R3,[R0+0x13]
    imem[15] = 32'h9060_0014;  // ST   R6,[R0+0x14]
    imem[16] = 32'h2080_4000;  // ADDI R8,R0,0x4000
    imem[17] = 32'h1688_0000;  // SHL1 R8,R8
    imem[18] = 32'h1688_0000;  // SHL1 R8,R8
    imem[19] = 32'h2070_0003;  // ADDI R7,R0,3
    imem[20] = 32'h1878_8000;  // MUL  R7,R8,R8
    imem[21] = 32'h9070_0015;  // ST   R7,[R0+0x15]
    imem[22] = 32'hF000_0000;  // HALT

    #1 rst_f = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_dmem_req_we", {dmem_req, dmem_we}, 2'b00);
    chk("rst_pc", pc, 16'h0);
    chk("rst_stat", stat, 4'h0);
    chk("rst_halted", halted, 1'b0);
    rst_f = 1'b1;
    #1 chk("rel_imem_req", imem_req, 1'b0);
    @(negedge clk);
    chk("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 16'h0);

    exec1(lat); chk("addi_lat", lat, 4); chk("addi_pc", pc, 16'd1); chk("addi_stat", stat, 4'b0000);
    exec1(lat); chk("addi_neg_stat", stat, 4'b0010);
    exec1(lat); chk("sub_lat", lat, 4); chk("sub_stat", stat, 4'b1001);
    exec1(lat); chk("jmp_lat", lat, 3); chk("jmp_pc", pc, 16'd5);
    exec1(lat); chk("bra_t_lat", lat, 3); chk("bra_t_pc", pc, 16'd4); chk("bra_t_stat", stat, 4'b1001);
    exec1(lat); chk("jmp6_pc", pc, 16'd6);
    exec1(lat); chk("ones_stat", stat, 4'b0010);
    exec1(lat); chk("shr_stat", stat, 4'b0000);
    exec1(lat); chk("ovf_stat", stat, 4'b0110);
    exec1(lat); chk("bra_nt_lat", lat, 3); chk("bra_nt_pc", pc, 16'd10);

    dly = 3; mon_en = 1'b1; mon_we = 1'b1; mon_addr = 16'h10; mon_wdata = 32'd5;
    exec1(lat); chk("st_lat", lat, 7); chk("st_mem", dmem[8'h10], 32'd5);
    mon_we = 1'b0;
    exec1(lat); chk("ld_lat", lat, 8);
    dly = 0; mon_en = 1'b0;
    exec1(lat); chk("st0_lat", lat, 4); chk("ld_r4", dmem[8'h11], 32'd5);
    chk("ldst_stat", stat, 4'b0110);
    exec1(lat); chk("r2_val", dmem[8'h12], 32'hFFFF_FFF9);
    exec1(lat); chk("r3_val", dmem[8'h13], 32'h0);
    exec1(lat); chk("r6_val", dmem[8'h14], 32'h8000_0000);
    exec1(lat);
    exec1(lat);
    exec1(lat); chk("shl_stat", stat, 4'b0000);
    exec1(lat);
    exec1(lat);
`ifdef SISC_MUL_EN
    chk("mul_lat", lat, 4);
    chk("mul_stat", stat, 4'b1001);
`else
    chk("mm8_nop_stat", stat, 4'b0000);
`endif
    exec1(lat);
`ifdef SISC_MUL_EN
    chk("mul_res", dmem[8'h15], 32'h0);
`else
    chk("mm8_nop_r7", dmem[8'h15], 32'd3);
`endif
    exec1(lat); chk("halt_flag", halted, 1'b1); chk("halt_pc", pc, 16'd23);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("halt_idle", {halted, imem_req, dmem_req}, 3'b100);
    end

    // Reset while a load waits in MEM, then a late ack during and after reset.
    rst_f = 1'b0;
    imem[0] = 32'h8050_0010;  // LD   R5,[R0+0x10]
    imem[1] = 32'hF000_0000;  // HALT
    dly = 100;
    @(negedge clk);
    rst_f = 1'b1;
    for (int i = 0; i < 20 && !dmem_req; i++) @(negedge clk);
    chk("mm_req_seen", dmem_req, 1'b1);
    @(negedge clk);
    #2 rst_f = 1'b0;
    #1;
    chk("mm_rst_req", {dmem_req, dmem_we}, 2'b00);
    chk("mm_rst_pc", pc, 16'h0);
    chk("mm_rst_imem", imem_req, 1'b0);
    ack_force = 1'b1;
    imem[0] = 32'h9050_0020;  // ST   R5,[R0+0x20]
    dly = 0;
    @(negedge clk);
    rst_f = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    chk("mm_refetch", {imem_req, imem_addr}, {1'b1, 16'h0});
    mon_en = 1'b1; mon_we = 1'b1; mon_addr = 16'h20; mon_wdata = 32'h0;
    exec1(lat); chk("mm_st_lat", lat, 4); chk("mm_r5_clear", dmem[8'h20], 32'h0);
    mon_en = 1'b0;
    exec1(lat); chk("mm_halt", {halted, pc}, {1'b1, 16'd2});

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/sisc_core.md
SISC_CORE -- requirements
Module: sisc_core

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register/ALU/data-memory word width (16..64).
REQ-002 SHALL have parameter NREG, default 16, meaning the number of implemented registers (2..16).
REQ-003 SHALL have parameter PC_W, default 16, meaning the width of the program counter and of both memory addresses (8..16).
REQ-004 SHALL have one clock and an asynchronous, active-low reset:
  clk  in  1  clock, all state updates on the rising edge;
  rst_f  in  1  asynchronous, active-low reset.
REQ-005 SHALL have these memory ports:
  imem_req  out  1  instruction fetch request;
  imem_addr  out  PC_W  fetch address (= pc);
  imem_rdata  in  32  instruction word;
  imem_ack  in  1  fetch complete; imem_rdata is valid in the same cycle;
  dmem_req  out  1  data access request;
  dmem_we  out  1  1 = store, 0 = load;
  dmem_addr  out  PC_W  data address;
  dmem_wdata  out  DATA_W  store data;
  dmem_rdata  in  DATA_W  load data; valid while dmem_ack = 1;
  dmem_ack  in  1  data access complete.
REQ-006 SHALL have these status ports:
  pc  out  PC_W  current program counter;
  stat  out  4  status flags {C,V,N,Z} = bits [3:0];
  halted  out  1  core is stopped.

Function
REQ-007 SHALL decode the instruction fields as: op = [31:28], mm = [27:24], rd = [23:20], rs = [19:16], rt = [15:12], imm = [15:0].
REQ-008 SHALL be a multicycle FSM with states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-009 SHALL hold imem_req = 1 in FETCH until an edge at which imem_ack = 1, then latch the IR and go to DECODE; a same-cycle ack is legal.
REQ-010 SHALL read rs and rt (rd for a store) in DECODE, register the operands and increment pc by 1 modulo 2^PC_W.
REQ-011 SHALL implement op 1 (ALU register): result = f(rs, rt), with mm 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT rs, 6 SHL1 rs, 7 SHR1 rs (logical).
REQ-012 SHALL implement op 2 (ALU immediate): same mm functions with sign-extended imm in place of rt.
REQ-013 SHALL write an ALU result to rd in WB and update stat at the same edge:
  - Z = result zero; N = result MSB;
  - C = carry out, or NOT borrow for SUB; V = signed overflow;
  - C and V = 0 for mm 2..7.
REQ-014 SHALL implement op 4 (relative branch), taken when mm = 0 or (mm & stat) != 0: pc <= pc + sext(imm), where pc is already incremented; the add wraps modulo 2^PC_W.
REQ-015 SHALL implement op 5 (absolute branch), same condition: pc <= imm[PC_W-1:0].
REQ-016 SHALL resolve branches in EXEC, go directly to FETCH, and leave stat unchanged.
REQ-017 SHALL implement op 8 (LOAD): rd <= M[rs + sext(imm)], with the address truncated to PC_W.
REQ-018 SHALL implement op 9 (STORE): M[rs + sext(imm)] <= rd.
REQ-019 SHALL hold dmem_req, dmem_we, dmem_addr and dmem_wdata stable in MEM until dmem_ack = 1 at an edge; LOAD then goes to WB, STORE to FETCH; loads and stores do not change stat.
REQ-020 SHALL make op 15 enter HALT; in HALT, halted = 1, no requests are issued, and only reset exits.
REQ-021 SHALL treat op 0 and every undefined op or mm code as a NOP (DECODE -> FETCH).
REQ-022 SHALL read a register index >= NREG as 0 and drop writes to it.
REQ-023 SHALL have zero-wait latency: ALU = 4 cycles, branch/NOP = 3, LOAD = 5, STORE = 4.

Reset
REQ-024 SHALL, while rst_f = 0 and independent of clk:
  - force state = FETCH and pc = 0, stat = 0, halted = 0;
  - drive imem_req = 0, dmem_req = 0 and dmem_we = 0;
  - clear all registers to 0.
REQ-025 SHALL abandon any outstanding request on reset; a late ack is ignored; imem_req rises at the first edge after rst_f rises.

Configuration
REQ-026 SHALL, when SISC_MUL_EN is defined, decode mm 8 of ops 1/2 as MUL: low DATA_W bits of the product, C = 1 when the high half is nonzero, V = 0, Z/N per REQ-013.
REQ-027 SHALL treat mm 8 as a NOP when SISC_MUL_EN is undefined, and synthesise no multiplier.

Structure
REQ-028 SHALL take the opcode constants, mm ALU codes, FSM state encoding and stat bit indices from package sisc_pkg.
REQ-029 SHALL place the ALU in sub-module sisc_alu (operands, mm -> result and flags); the register file and FSM SHALL remain in sisc_core.

Verification
REQ-030 SHALL cover reset with zero-wait memories: after release, first fetch at imem_addr 0; ADDI R1,R0,5 then ADDI R2,R0,-7 -> R1 = 5, R2 = 0xFFFFFFF9, stat = 0b0010.
REQ-031 SHALL cover SUB R3,R1,R1 -> R3 = 0, stat = 0b1001; then BRA mm = 0001, imm = -2 taken -> pc decrements by 1 net.
REQ-032 SHALL cover ADD of 0x7FFFFFFF + 1 -> 0x80000000, stat = 0b0110; BRA mm = 0001 not taken -> pc + 1.
REQ-033 SHALL cover STORE R1 to 0x10 then LOAD R4 from 0x10 with dmem_ack delayed 3 cycles -> request held stable, R4 = 5, STORE takes 7 cycles.
REQ-034 SHALL cover rst_f asserted mid-MEM -> dmem_req drops at once, pc = 0, and a late ack causes no write.
REQ-035 SHALL cover HALT, then 20 cycles -> halted = 1 and no requests; with SISC_MUL_EN, MUL 0x10000 * 0x10000 -> 0, C = 1, Z = 1.
